fp_mant_addsub_pipe: RTL and testbench
======================================

Name: fp_mant_addsub_pipe

Overview:
- Parametrised, two-stage pipelined mantissa add/subtract and normalise-prep unit for the FP adder datapath.
- Takes exponent-aligned mantissas plus alignment sticky. Performs effective add or subtract with magnitude compare, IEEE-754 signed-zero rules and sticky-correct subtraction, then computes a leading-zero count and left-normalised mantissa.
- Sits between the align stage and the round/pack stage, with valid/ready handshaking and flush so it can stall under backpressure from the FPU writeback.

Parameters:
- MW, 48, aligned mantissa width in bits (>=8).
- TW, 5, width of the pass-through tag (e.g. destination register index).
- LZW, $clog2(MW+1), width of the leading-zero count; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  drop all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit can accept an operation this cycle.
- in_sign_a  in  1  sign of operand A.
- in_sign_b  in  1  sign of operand B before op.
- in_op_sub  in  1  1 = A-B, 0 = A+B.
- in_mant_a  in  MW  aligned mantissa A.
- in_mant_b  in  MW  aligned mantissa B.
- in_sticky  in  1  OR of bits shifted out of the smaller operand during alignment.
- in_a_zero  in  1  operand A is ±0.
- in_b_zero  in  1  operand B is ±0.
- in_rm  in  3  rounding mode; 3'b010 = RDN.
- in_tag  in  TW  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_mant  out  MW  normalised mantissa.
- out_carry  out  1  add overflowed by one bit; exponent +1.
- out_lzc  out  LZW  left shift applied; exponent -out_lzc.
- out_sign  out  1  result sign.
- out_sticky  out  1  sticky for rounding.
- out_zero  out  1  exact zero result.
- out_tag  out  TW  tag of this result.

Behaviour:
- Reset (reset_n=0, asynchronous): both stage-valid flags clear; out_valid=0. All output data registers clear to 0 (out_mant, out_carry, out_lzc, out_sign, out_sticky, out_zero, out_tag). in_ready=1 once reset releases.
- Pipeline structure: S1 register holds add/sub results; S2 register holds normalised outputs. Latency is exactly 2 cycles with no stalls.
- Throughput: 1 operation per cycle.
- S2 advance: S2 loads when ~s2_valid | out_ready.
- S1 advance: S1 loads when ~s1_valid | S2 loads.
- in_ready: in_ready = ~s1_valid | s2_load. An operation is accepted on in_valid & in_ready.
- Stall: if out_valid=1 and out_ready=0, all registers hold their contents and outputs stay stable.
- Stage 1 arithmetic, effective sign: sb = in_sign_b ^ in_op_sub.
  - sign_a == sb: sum = {1'b0,A} + {1'b0,B} (MW+1 bits); sign = sign_a; sticky = in_sticky.
  - Signs differ, A>B: diff = A-B-in_sticky; sign = sign_a.
  - Signs differ, B>A: diff = B-A-in_sticky; sign = sb.
  - In both differing-sign cases sticky = in_sticky; the borrow models the shifted-out fraction.
  - Signs differ, A==B: result 0, sticky 0, sign = (in_rm==3'b010).
  - Both operands zero: result 0. Sign = sign_a if sign_a==sb, else (in_rm==3'b010).
  - Tag passes through unchanged.
- Stage 2 normalise:
  - sum[MW]=1: out_carry=1; out_mant = sum[MW:1]; out_sticky = sticky | sum[0]; out_lzc=0.
  - Otherwise: out_carry=0; out_lzc = count of leading zeros of sum[MW-1:0]; out_mant = sum[MW-1:0] << out_lzc; out_sticky = sticky.
  - sum==0: out_zero=1, out_lzc=MW, out_mant=0. out_sticky is forced to 0 when the result is exact zero.
- Flush: both stage-valid flags clear on the next edge. An input handshaking in the same cycle as flush is discarded. Flush has priority over stall.
- Reset mid-operation: in-flight operations are lost. No partial output is ever presented.

Test Plan:
- MW=48, same sign: A=48'h8000_0000_0000, B=48'h8000_0000_0000, op_sub=0, sticky=0 -> after 2 cycles out_carry=1, out_mant=48'h8000_0000_0000, out_lzc=0, out_sticky=0.
- Subtract with sticky: A=48'h8000_0000_0000, B=48'h0000_0000_0001, in_sticky=1, op_sub=1 -> out_mant=48'hFFFF_FFFF_FFFC, out_lzc=1, out_sticky=1, out_sign=sign_a.
- Exact cancellation: A=B=48'hC000_0000_0000, op_sub=1 -> out_zero=1, out_lzc=48. out_sign=0 with in_rm=3'b000, out_sign=1 with in_rm=3'b010. Also +0 + -0 -> same sign rule.
- Backpressure: stream tags 1..6 back-to-back, hold out_ready=0 for 3 cycles mid-stream -> in_ready drops within 1 cycle, outputs stay stable while stalled, all six tags emerge in order with no loss or duplication.
- Flush: 2 operations in flight, assert flush for 1 cycle together with a new in_valid -> out_valid=0 next cycle, and no results for any of the 3 operations ever appear.
- Async reset: assert reset_n=0 mid-stream between clock edges -> out_valid and all outputs are 0 immediately, and in_ready=1 after release.

Source files
------------

// File: rtl/fp_mant_addsub_pipe.sv
// Two-stage mantissa add/subtract with leading-zero normalise for the FP adder.
// S1 registers the signed magnitude result, S2 registers the normalised mantissa and shift count.
module fp_mant_addsub_pipe #(
    parameter int MW = 48,
    parameter int TW = 5,
    localparam int LZW = $clog2(MW + 1)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_sign_a,
    input  logic           in_sign_b,
    input  logic           in_op_sub,
    input  logic [MW-1:0]  in_mant_a,
    input  logic [MW-1:0]  in_mant_b,
    input  logic           in_sticky,
    input  logic           in_a_zero,
    input  logic           in_b_zero,
    input  logic [2:0]     in_rm,
    input  logic [TW-1:0]  in_tag,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [MW-1:0]  out_mant,
    output logic           out_carry,
    output logic [LZW-1:0] out_lzc,
    output logic           out_sign,
    output logic           out_sticky,
    output logic           out_zero,
    output logic [TW-1:0]  out_tag
);
    localparam logic [2:0] RM_RDN = 3'b010;

    logic          s1_valid, s2_valid;
    logic          s1_load, s2_load, accept;
    logic [MW:0]   s1_sum;
    logic          s1_sign, s1_sticky;
    logic [TW-1:0] s1_tag;

    assign s2_load   = ~s2_valid | out_ready;
    assign s1_load   = ~s1_valid | s2_load;
    assign in_ready  = s1_load;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid;

    // Stage 1: effective operation and magnitude compare
    logic          eff_b, rdn;
    logic [MW:0]   st1_sum;
    logic          st1_sign, st1_sticky;

    always_comb begin
        eff_b      = in_sign_b ^ in_op_sub;
        rdn        = (in_rm == RM_RDN);
        st1_sum    = '0;
        st1_sign   = in_sign_a;
        st1_sticky = in_sticky;
        if (in_a_zero && in_b_zero) begin
            st1_sticky = 1'b0;
            st1_sign   = (in_sign_a == eff_b) ? in_sign_a : rdn;
        end else if (in_sign_a == eff_b) begin
            st1_sum = {1'b0, in_mant_a} + {1'b0, in_mant_b};
        end else if (in_mant_a == in_mant_b) begin
            st1_sticky = 1'b0;
            st1_sign   = rdn;
        end else if (in_mant_a > in_mant_b) begin
            // Borrowing the sticky accounts for the fraction shifted out of B
            st1_sum = {1'b0, in_mant_a} - {1'b0, in_mant_b} - (MW+1)'(in_sticky);
        end else begin
            st1_sum  = {1'b0, in_mant_b} - {1'b0, in_mant_a} - (MW+1)'(in_sticky);
            st1_sign = eff_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_sign   <= 1'b0;
            s1_sticky <= 1'b0;
            s1_tag    <= '0;
        end else begin
            if (flush)
                s1_valid <= 1'b0;
            else if (s1_load)
                s1_valid <= in_valid;
            if (accept && !flush) begin
                s1_sum    <= st1_sum;
                s1_sign   <= st1_sign;
                s1_sticky <= st1_sticky;
                s1_tag    <= in_tag;
            end
        end
    end

    // Stage 2: leading-zero count and left normalise
    logic [LZW-1:0] lz;
    logic           lz_found;
    logic [MW-1:0]  st2_mant;
    logic           st2_carry, st2_sticky, st2_zero;
    logic [LZW-1:0] st2_lzc;

    always_comb begin
        lz       = LZW'(MW);
        lz_found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!lz_found && s1_sum[i]) begin
                lz       = LZW'(MW - 1 - i);
                lz_found = 1'b1;
            end
        end
        if (s1_sum[MW]) begin
            st2_carry  = 1'b1;
            st2_mant   = s1_sum[MW:1];
            st2_lzc    = '0;
            st2_sticky = s1_sticky | s1_sum[0];
            st2_zero   = 1'b0;
        end else begin
            st2_carry  = 1'b0;
            st2_mant   = s1_sum[MW-1:0] << lz;
            st2_lzc    = lz;
            st2_zero   = ~lz_found;
            st2_sticky = s1_sticky & lz_found;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid   <= 1'b0;
            out_mant   <= '0;
            out_carry  <= 1'b0;
            out_lzc    <= '0;
            out_sign   <= 1'b0;
            out_sticky <= 1'b0;
            out_zero   <= 1'b0;
            out_tag    <= '0;
        end else begin
            if (flush)
                s2_valid <= 1'b0;
            else if (s2_load)
                s2_valid <= s1_valid;
            if (s2_load && s1_valid && !flush) begin
                out_mant   <= st2_mant;
                out_carry  <= st2_carry;
                out_lzc    <= st2_lzc;
                out_sign   <= s1_sign;
                out_sticky <= st2_sticky;
                out_zero   <= st2_zero;
                out_tag    <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_fp_mant_addsub_pipe.sv
// Directed bench for fp_mant_addsub_pipe: vector table plus backpressure, flush and async reset sequences.
module tb_fp_mant_addsub_pipe;
    localparam int MW = 48;
    localparam int TW = 5;
    localparam int LZW = 6;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_sign_a = 1'b0, in_sign_b = 1'b0, in_op_sub = 1'b0;
    logic [MW-1:0]  in_mant_a = '0, in_mant_b = '0;
    logic           in_sticky = 1'b0, in_a_zero = 1'b0, in_b_zero = 1'b0;
    logic [2:0]     in_rm = 3'b000;
    logic [TW-1:0]  in_tag = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [MW-1:0]  out_mant;
    logic           out_carry;
    logic [LZW-1:0] out_lzc;
    logic           out_sign, out_sticky, out_zero;
    logic [TW-1:0]  out_tag;

    int checks = 0;
    int failures = 0;

    fp_mant_addsub_pipe #(.MW(MW), .TW(TW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign_a(in_sign_a), .in_sign_b(in_sign_b), .in_op_sub(in_op_sub),
        .in_mant_a(in_mant_a), .in_mant_b(in_mant_b), .in_sticky(in_sticky),
        .in_a_zero(in_a_zero), .in_b_zero(in_b_zero), .in_rm(in_rm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_carry(out_carry), .out_lzc(out_lzc),
        .out_sign(out_sign), .out_sticky(out_sticky), .out_zero(out_zero), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sa, sb, sub;
        logic [MW-1:0] a, b;
        logic          stk, az, bz;
        logic [2:0]    rm;
        logic [TW-1:0] tag;
        logic [MW-1:0] emant;
        logic          ecarry;
        logic [LZW-1:0] elzc;
        logic          esign, estk, ezero;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic set_op(input logic sa, input logic sb, input logic sub,
                          input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input logic stk, input logic az, input logic bz,
                          input logic [2:0] rm, input logic [TW-1:0] tag);
        in_sign_a = sa; in_sign_b = sb; in_op_sub = sub;
        in_mant_a = a;  in_mant_b = b;  in_sticky = stk;
        in_a_zero = az; in_b_zero = bz; in_rm = rm; in_tag = tag;
    endtask

    function automatic logic [62:0] outs();
        return {out_mant, out_carry, out_lzc, out_sign, out_sticky, out_zero, out_tag};
    endfunction

    initial begin
        //                sa sb sub a                  b                  stk az bz rm      tag    emant              cy lzc sg st z
        vecs[0]  = '{0, 0, 0, 48'h8000_0000_0000, 48'h8000_0000_0000, 0, 0, 0, 3'b000, 5'd1,  48'h8000_0000_0000, 1, 6'd0,  0, 0, 0};
        vecs[1]  = '{1, 1, 1, 48'h8000_0000_0000, 48'h0000_0000_0001, 1, 0, 0, 3'b000, 5'd2,  48'hFFFF_FFFF_FFFC, 0, 6'd1,  1, 1, 0};
        vecs[2]  = '{0, 0, 1, 48'hC000_0000_0000, 48'hC000_0000_0000, 0, 0, 0, 3'b000, 5'd3,  48'h0,              0, 6'd48, 0, 0, 1};
        vecs[3]  = '{0, 0, 1, 48'hC000_0000_0000, 48'hC000_0000_0000, 0, 0, 0, 3'b010, 5'd4,  48'h0,              0, 6'd48, 1, 0, 1};
        vecs[4]  = '{0, 1, 0, 48'h0,              48'h0,              0, 1, 1, 3'b000, 5'd5,  48'h0,              0, 6'd48, 0, 0, 1};
        vecs[5]  = '{0, 1, 0, 48'h0,              48'h0,              0, 1, 1, 3'b010, 5'd6,  48'h0,              0, 6'd48, 1, 0, 1};
        vecs[6]  = '{1, 1, 0, 48'h0,              48'h0,              0, 1, 1, 3'b000, 5'd7,  48'h0,              0, 6'd48, 1, 0, 1};
        vecs[7]  = '{0, 0, 1, 48'h0000_0000_1000, 48'h0000_0000_3000, 0, 0, 0, 3'b000, 5'd8,  48'h8000_0000_0000, 0, 6'd34, 1, 0, 0};
        vecs[8]  = '{0, 0, 0, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0002, 0, 0, 0, 3'b000, 5'd9,  48'h8000_0000_0000, 1, 6'd0,  0, 1, 0};
        vecs[9]  = '{1, 1, 0, 48'h0000_0000_1234, 48'h0000_0000_0001, 1, 0, 0, 3'b000, 5'd10, 48'h91A8_0000_0000, 0, 6'd35, 1, 1, 0};
        vecs[10] = '{0, 0, 1, 48'h0000_0000_0002, 48'h0000_0000_0001, 1, 0, 0, 3'b000, 5'd11, 48'h0,              0, 6'd48, 0, 0, 1};
        vecs[11] = '{0, 0, 1, 48'h0,              48'h4000_0000_0000, 0, 1, 0, 3'b000, 5'd12, 48'h8000_0000_0000, 0, 6'd1,  1, 0, 0};

        // Reset state
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset outputs", 64'(outs()), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1 chk("reset in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Vector table, latency 2 from presentation
        for (int i = 0; i < 12; i++) begin
            set_op(vecs[i].sa, vecs[i].sb, vecs[i].sub, vecs[i].a, vecs[i].b,
                   vecs[i].stk, vecs[i].az, vecs[i].bz, vecs[i].rm, vecs[i].tag);
            in_valid = 1'b1;
            #1 chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d mant", i), 64'(out_mant), 64'(vecs[i].emant));
            chk($sformatf("v%0d carry/lzc/sign/sticky/zero/tag", i),
                64'({out_carry, out_lzc, out_sign, out_sticky, out_zero, out_tag}),
                64'({vecs[i].ecarry, vecs[i].elzc, vecs[i].esign, vecs[i].estk, vecs[i].ezero, vecs[i].tag}));
        end
        @(posedge clk); #1;
        chk("drain out_valid", 64'(out_valid), 64'd0);

        // Backpressure: tags 1..6 streamed, out_ready low for cycles 4..6
        begin
            int tn;
            logic [TW-1:0] got[$];
            logic [TW-1:0] hold_tag;
            logic [MW-1:0] hold_mant;
            tn = 1;
            hold_tag = '0;
            hold_mant = '0;
            for (int c = 0; c < 30; c++) begin
                out_ready = !(c >= 4 && c < 7);
                in_valid = (tn <= 6);
                set_op(0, 0, 0, 48'(tn) << 20, 48'h1, 0, 0, 0, 3'b000, TW'(tn));
                #1;
                if (c == 4) begin
                    chk("bp out_valid at stall", 64'(out_valid), 64'd1);
                    hold_tag = out_tag;
                    hold_mant = out_mant;
                end
                if (c == 5 || c == 6) begin
                    chk($sformatf("bp c%0d in_ready", c), 64'(in_ready), 64'd0);
                    chk($sformatf("bp c%0d out_valid", c), 64'(out_valid), 64'd1);
                    chk($sformatf("bp c%0d tag stable", c), 64'(out_tag), 64'(hold_tag));
                    chk($sformatf("bp c%0d mant stable", c), 64'(out_mant), 64'(hold_mant));
                end
                if (out_valid && out_ready) got.push_back(out_tag);
                if (in_valid && in_ready) tn++;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            chk("bp result count", 64'(got.size()), 64'd6);
            for (int k = 0; k < 6; k++)
                if (k < got.size())
                    chk($sformatf("bp order %0d", k), 64'(got[k]), 64'(k + 1));
        end

        // Flush with two ops in flight and a third arriving
        begin
            int seen;
            seen = 0;
            out_ready = 1'b0;
            set_op(0, 0, 0, 48'h1000, 48'h1, 0, 0, 0, 3'b000, 5'd20);
            in_valid = 1'b1;
            @(posedge clk); #1;
            set_op(0, 0, 0, 48'h2000, 48'h1, 0, 0, 0, 3'b000, 5'd21);
            @(posedge clk); #1;
            set_op(0, 0, 0, 48'h3000, 48'h1, 0, 0, 0, 3'b000, 5'd22);
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            in_valid = 1'b0;
            chk("flush out_valid", 64'(out_valid), 64'd0);
            chk("flush in_ready", 64'(in_ready), 64'd1);
            out_ready = 1'b1;
            for (int c = 0; c < 6; c++) begin
                if (out_valid) seen++;
                @(posedge clk); #1;
            end
            chk("flush no results", 64'(seen), 64'd0);
        end

        // Async reset between edges while results are in flight
        begin
            int seen;
            seen = 0;
            set_op(0, 0, 0, 48'hABCD_0000, 48'h1, 1, 0, 0, 3'b000, 5'd9);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_tag = 5'd10;
            @(posedge clk); #1;
            chk("rst pre out_valid", 64'(out_valid), 64'd1);
            #2 reset_n = 1'b0;
            #1;
            chk("rst async out_valid", 64'(out_valid), 64'd0);
            chk("rst async outputs", 64'(outs()), 64'd0);
            in_valid = 1'b0;
            @(posedge clk);
            #3 reset_n = 1'b1;
            #1 chk("rst release in_ready", 64'(in_ready), 64'd1);
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("rst no partial output", 64'(seen), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
